imem_arbiter: RTL

- Shares the single-port instruction memory between two requesters: the core fetch port and the program loader port (boot-time image load; run-time patching).
- Sits between the fetch stage / loader and a 1-cycle-latency synchronous SRAM that holds the 0x8000_0000–0x8000_FFFF instruction region.
- Sequences a BOOT phase, in which only the loader is served, then a RUN phase with fetch priority and bounded loader starvation.

---
 rtl/imem_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - instruction memory arbiter between core fetch and program loader
module imem_arbiter #(
    parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
    parameter int          DEPTH_LOG2      = 14,
    parameter int          MAX_FETCH_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_req_i,
    input  logic [31:0]           f_addr_i,
    output logic                  f_gnt_o,
    output logic                  f_rvalid_o,
    output logic [31:0]           f_rdata_o,
    output logic                  f_err_o,
    input  logic                  l_req_i,
    input  logic                  l_we_i,
    input  logic [31:0]           l_addr_i,
    input  logic [31:0]           l_wdata_i,
    input  logic                  l_done_i,
    output logic                  l_gnt_o,
    output logic                  l_rvalid_o,
    output logic [31:0]           l_rdata_o,
    output logic                  l_err_o,
    output logic                  boot_o,
    output logic                  m_en_o,
    output logic                  m_we_o,
    output logic [DEPTH_LOG2-1:0] m_addr_o,
    output logic [31:0]           m_wdata_o,
    input  logic [31:0]           m_rdata_i
);

    localparam int CW = $clog2(MAX_FETCH_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_FETCH_BURST);

    typedef enum logic {
        ST_BOOT,
        ST_RUN
    } state_t;

    state_t          state;
    logic [CW-1:0]   burst_cnt;
    logic            rsp_f;
    logic            rsp_l;
    logic            rsp_err;
    logic            rsp_rd;

    logic [31:0]     sel_addr;
    logic [31:0]     offset;
    logic            fault;
    logic            any_gnt;

    // Grant selection: loader only in BOOT; in RUN fetch wins unless the loader has starved for a full burst.
    // Grants are held off while reset is asserted so nothing reaches the SRAM during reset.
    always_comb begin
        f_gnt_o = 1'b0;
        l_gnt_o = 1'b0;
        if (rst_n) begin
            if (state == ST_BOOT) begin
                l_gnt_o = l_req_i;
            end else if (l_req_i && (burst_cnt == BURST_MAX)) begin
                l_gnt_o = 1'b1;
            end else if (f_req_i) begin
                f_gnt_o = 1'b1;
            end else begin
                l_gnt_o = l_req_i;
            end
        end
    end

    // Decode the winning request into an SRAM word index and a fault flag.
    // BASE_ADDR is word aligned, so offset[1:0] equals the request's low address bits.
    always_comb begin
        any_gnt   = f_gnt_o | l_gnt_o;
        sel_addr  = f_gnt_o ? f_addr_i : l_addr_i;
        offset    = sel_addr - BASE_ADDR;
        fault     = (|offset[1:0]) | (|offset[31:DEPTH_LOG2+2]);
        m_en_o    = any_gnt & ~fault;
        m_we_o    = l_gnt_o & l_we_i & ~fault;
        m_addr_o  = offset[DEPTH_LOG2+1:2];
        m_wdata_o = l_wdata_i;
    end

    // Phase FSM: BOOT until the loader signals completion, then RUN until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else if ((state == ST_BOOT) && l_done_i) begin
            state <= ST_RUN;
        end
    end

    // Count fetch grants taken while the loader waits; any loader grant or idle loader clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (!l_req_i || l_gnt_o) begin
            burst_cnt <= '0;
        end else if (f_gnt_o && (burst_cnt != BURST_MAX)) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    // Remember who was granted and what kind of access it was, for the response one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_f   <= 1'b0;
            rsp_l   <= 1'b0;
            rsp_err <= 1'b0;
            rsp_rd  <= 1'b0;
        end else begin
            rsp_f   <= f_gnt_o;
            rsp_l   <= l_gnt_o;
            rsp_err <= any_gnt & fault;
            rsp_rd  <= any_gnt & ~fault & ~(l_gnt_o & l_we_i);
        end
    end

    // Response outputs: a response pending across a reset edge is suppressed while reset is low.
    always_comb begin
        boot_o     = (state == ST_BOOT) | ~rst_n;
        f_rvalid_o = rsp_f & rst_n;
        l_rvalid_o = rsp_l & rst_n;
        f_err_o    = f_rvalid_o & rsp_err;
        l_err_o    = l_rvalid_o & rsp_err;
        f_rdata_o  = (f_rvalid_o & rsp_rd) ? m_rdata_i : 32'h0;
        l_rdata_o  = (l_rvalid_o & rsp_rd) ? m_rdata_i : 32'h0;
    end

endmodule
